fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer between the PC register and the instruction-memory port. It latches the current PC into a memory address, runs a read handshake with memory, loads the returned word into the instruction register (IR), and drives the PC register's `incPC`/`enable` inputs to advance the PC by 4 after each successful fetch. A branch redirect aborts the fetch in flight and suppresses the increment, so upstream logic can load the target PC.

## Interface
Parameters:
- `RESET_IR`, default 0: value loaded into IR on `clear`.

Ports:
- `clock`, in, 1: the single clock; all state changes on its rising edge.
- `clear`, in, 1: asynchronous, active-high reset.
- `fetch_go`, in, 1: level request from the control unit to start a fetch; sampled in IDLE only.
- `PC`, in, 32: current PC register value.
- `redirect`, in, 1: branch/jump taken; aborts or discards the current fetch.
- `mem_addr`, out, 32: registered read address.
- `mem_read`, out, 1: read request; high exactly while in REQ.
- `mem_ready`, in, 1: memory data valid this cycle.
- `mem_rdata`, in, 32: memory read data.
- `IR`, out, 32: instruction register.
- `ir_valid`, out, 1: IR holds an unconsumed instruction.
- `ir_ack`, in, 1: decode has consumed IR.
- `incPC`, out, 1: drives the PC register's increment input.
- `pc_enable`, out, 1: drives the PC register's enable input; at top level it is OR'd with the branch-load enable.
- `busy`, out, 1: state is not IDLE.
- `fetch_count`, out, 32: performance counter (see Configuration).
- `stall_count`, out, 32: performance counter (see Configuration).

## Operation
States: IDLE, REQ, HOLD.

- **IDLE:**
  - `fetch_go`=1 and `redirect`=0 → REQ, with `mem_addr <= PC`.
  - Otherwise stay in IDLE.
- **REQ:** `mem_read`=1.
  - `redirect`=1 → IDLE. Data is discarded, IR is unchanged, and no increment occurs. Redirect wins even if `mem_ready`=1 in the same cycle.
  - `mem_ready`=1 → HOLD, with `IR <= mem_rdata`, `ir_valid <= 1`, `inc_pending <= 1`.
  - Otherwise stay in REQ. Wait time is unbounded.
- **HOLD:**
  - `redirect`=1 → IDLE with `ir_valid <= 0`. The redirect takes priority over a simultaneous `ir_ack`.
  - `ir_ack`=1 → IDLE with `ir_valid <= 0`.
  - Otherwise stay in HOLD. IR is held stable.
- **PC increment:**
  - `inc_pending` is a one-cycle registered flag; it self-clears on the next edge.
  - `incPC = pc_enable = inc_pending & ~redirect`, combinational on `redirect` only.
  - A redirect in the increment cycle therefore leaves `incPC`=0, so the PC register loads `instruct_PC` (the branch target).
- **Reset (`clear`):** asynchronous. State → IDLE; `mem_addr`=0, `IR`=`RESET_IR`, `ir_valid`=0, `inc_pending`=0, and both counters 0. Consequently `mem_read`, `incPC`, `pc_enable` and `busy` are all 0. Reset mid-fetch abandons the request immediately; any later `mem_ready` is ignored.
- `mem_rdata` is ignored outside REQ.
- `ir_ack` is ignored outside HOLD.

## Timing
- `fetch_go` sampled at edge 0 → `mem_read`=1 and `mem_addr`=PC from cycle 1.
- `mem_ready` first high at edge k → IR and `ir_valid` updated after edge k; `incPC`/`pc_enable` high during cycle k+1; PC shows PC+4 after edge k+1.
- `ir_ack` earliest at edge k+1 → IDLE after k+1. Next REQ after edge k+2 latches the already-incremented PC.
- Minimum throughput: 3 cycles per instruction (zero-wait memory, `fetch_go` and `ir_ack` held high).
- `mem_read` is a Moore output; `mem_addr` stays constant for the whole REQ residency.

## Configuration
- **Macro:** `FETCH_PERF_CNT_EN`.
- **Defined:**
  - `fetch_count` increments on every IR load.
  - `stall_count` increments on every cycle spent in REQ with `mem_ready`=0 (including the cycle a redirect aborts).
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear only on `clear`.
- **Undefined:** both ports are present but tied to 0, and no counter logic is synthesized.

## Test plan
- **Reset:** assert `clear` mid-REQ, asynchronously between edges → `mem_read`, `ir_valid`, `incPC` and `busy` drop to 0 immediately; IR = `RESET_IR`.
- **Zero-wait fetch:**
  - Stimulus: PC=0x100, `mem_ready` tied high, `mem_rdata`=0xDEADBEEF, `fetch_go`=1, `ir_ack`=1.
  - Response: `mem_addr`=0x100; IR=0xDEADBEEF; single-cycle `incPC`+`pc_enable` pulse; next fetch `mem_addr`=0x104; 3 cycles per fetch.
- **Wait states:** `mem_ready` delayed 4 cycles → `mem_read` held 5 cycles with constant `mem_addr`; `stall_count`=4 with the macro, 0 without.
- **Redirect in REQ coincident with `mem_ready`** → IR unchanged, no `incPC` pulse, IDLE next cycle, `fetch_count` unchanged.
- **Redirect during the `incPC` cycle** (instruct_PC=0x200 on the PC register) → `incPC`=`pc_enable`=0 from the fetch unit, PC=0x200 (not 0x104), `ir_valid` cleared.
- **HOLD backpressure:** `ir_ack` low for 10 cycles → IR stable, `mem_read`=0 and `busy`=1 throughout; release → IDLE.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer sitting between the PC register and
// the instruction-memory read port. Latches PC into mem_addr, runs the read
// handshake, loads IR, and pulses incPC/pc_enable one cycle after each load.
// A redirect aborts a fetch in flight or discards a held instruction, and
// cancels a pending increment so the PC register can load the branch target.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is
// defined; otherwise fetch_count and stall_count are tied to zero.
module fetch_unit #(
   parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        fetch_go,
   input  logic [31:0] PC,
   input  logic        redirect,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] IR,
   output logic        ir_valid,
   input  logic        ir_ack,
   output logic        incPC,
   output logic        pc_enable,
   output logic        busy,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] ir_q, ir_d;
   logic        ir_valid_q, ir_valid_d;
   logic        inc_pending_q, inc_pending_d;

   // Next-state logic: redirect always wins over a memory response or an ack,
   // and inc_pending is only ever high for the single cycle after an IR load.
   always_comb begin
      state_d       = state_q;
      mem_addr_d    = mem_addr_q;
      ir_d          = ir_q;
      ir_valid_d    = ir_valid_q;
      inc_pending_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fetch_go && !redirect) begin
               state_d    = ST_REQ;
               mem_addr_d = PC;
            end
         end
         ST_REQ: begin
            if (redirect) begin
               state_d = ST_IDLE;
            end else if (mem_ready) begin
               state_d       = ST_HOLD;
               ir_d          = mem_rdata;
               ir_valid_d    = 1'b1;
               inc_pending_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (redirect || ir_ack) begin
               state_d    = ST_IDLE;
               ir_valid_d = 1'b0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            ir_valid_d = 1'b0;
         end
      endcase
   end

   // State register; clear abandons any fetch immediately.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q       <= ST_IDLE;
         mem_addr_q    <= 32'h0000_0000;
         ir_q          <= RESET_IR;
         ir_valid_q    <= 1'b0;
         inc_pending_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_addr_q    <= mem_addr_d;
         ir_q          <= ir_d;
         ir_valid_q    <= ir_valid_d;
         inc_pending_q <= inc_pending_d;
      end
   end

   // Outputs: mem_read and busy are Moore; the increment is gated live by
   // redirect so a branch in the increment cycle lets the target load instead.
   always_comb begin
      mem_read  = (state_q == ST_REQ);
      busy      = (state_q != ST_IDLE);
      incPC     = inc_pending_q & ~redirect;
      pc_enable = inc_pending_q & ~redirect;
      mem_addr  = mem_addr_q;
      IR        = ir_q;
      ir_valid  = ir_valid_q;
   end

`ifdef FETCH_PERF_CNT_EN
   logic        ir_load;
   logic        req_stall;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] stall_count_q, stall_count_d;

   assign ir_load   = (state_q == ST_REQ) & ~redirect & mem_ready;
   assign req_stall = (state_q == ST_REQ) & ~mem_ready;

   // Counter increments: loads into IR, and REQ cycles with no data, which
   // includes a cycle aborted by redirect. Both wrap naturally at 32 bits.
   always_comb begin
      fetch_count_d = fetch_count_q + (ir_load ? 32'd1 : 32'd0);
      stall_count_d = stall_count_q + (req_stall ? 32'd1 : 32'd0);
   end

   // Counter registers, cleared only by clear.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         fetch_count_q <= 32'h0000_0000;
         stall_count_q <= 32'h0000_0000;
      end else begin
         fetch_count_q <= fetch_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;
`else
   assign fetch_count = 32'h0000_0000;
   assign stall_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Inputs change on the
// falling edge, outputs are sampled shortly after, and a transaction-level
// reference model (plus a model PC register) predicts every output.
module tb_fetch_unit;

   localparam logic [31:0] TB_RESET_IR = 32'h0000_0013;

   logic        clock;
   logic        clear;
   logic        fetch_go;
   logic [31:0] PC;
   logic        redirect;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] IR;
   logic        ir_valid;
   logic        ir_ack;
   logic        incPC;
   logic        pc_enable;
   logic        busy;
   logic [31:0] fetch_count;
   logic [31:0] stall_count;

   int passed;
   int total;

   // Reference model: whether a read is outstanding, whether an instruction
   // is waiting for decode, whether an increment is owed this cycle, and the
   // running totals of loads and empty request cycles.
   bit          m_fetching;
   bit          m_holding;
   bit          m_inc_due;
   logic [31:0] m_ir;
   logic [31:0] m_addr;
   int          m_fetches;
   int          m_stalls;
   logic [31:0] pc_reg;
   logic [31:0] target_pc;

   typedef struct {
      logic        go;
      logic        redir;
      logic        rdy;
      logic [31:0] pc;
      logic [31:0] rdata;
      logic        ack;
      logic        exp_read;
      logic        exp_busy;
      logic        exp_valid;
      logic        exp_inc;
      logic [31:0] exp_addr;
      logic [31:0] exp_ir;
      int          exp_fetches;
   } vec_t;

   vec_t vecs[6];

   fetch_unit #(.RESET_IR(TB_RESET_IR)) dut (
      .clock       (clock),
      .clear       (clear),
      .fetch_go    (fetch_go),
      .PC          (PC),
      .redirect    (redirect),
      .mem_addr    (mem_addr),
      .mem_read    (mem_read),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .IR          (IR),
      .ir_valid    (ir_valid),
      .ir_ack      (ir_ack),
      .incPC       (incPC),
      .pc_enable   (pc_enable),
      .busy        (busy),
      .fetch_count (fetch_count),
      .stall_count (stall_count)
   );

   // Free-running 10-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] cntExp(input int n);
`ifdef FETCH_PERF_CNT_EN
      return n;
`else
      return 32'h0 & n;
`endif
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   task automatic modelReset();
      m_fetching = 0;
      m_holding  = 0;
      m_inc_due  = 0;
      m_ir       = TB_RESET_IR;
      m_addr     = 32'h0;
      m_fetches  = 0;
      m_stalls   = 0;
   endtask

   // Advance the model over one rising edge using the inputs just applied.
   task automatic modelStep(input bit go, input bit redir, input bit rdy,
                            input logic [31:0] rdata, input bit ack);
      bit inc_now;
      inc_now   = m_inc_due && !redir;
      m_inc_due = 0;
      if (m_fetching) begin
         if (!rdy) m_stalls++;
         if (redir) begin
            m_fetching = 0;
         end else if (rdy) begin
            m_ir       = rdata;
            m_fetching = 0;
            m_holding  = 1;
            m_inc_due  = 1;
            m_fetches++;
         end
      end else if (m_holding) begin
         if (redir || ack) m_holding = 0;
      end else if (go && !redir) begin
         m_fetching = 1;
         m_addr     = pc_reg;
      end
      if (redir) pc_reg = target_pc;
      else if (inc_now) pc_reg = pc_reg + 32'd4;
   endtask

   task automatic checkOutput();
      bit exp_inc;
      exp_inc = m_inc_due && !redirect;
      cmp("mem_read",    {31'b0, mem_read},  {31'b0, m_fetching});
      cmp("busy",        {31'b0, busy},      {31'b0, m_fetching | m_holding});
      cmp("ir_valid",    {31'b0, ir_valid},  {31'b0, m_holding});
      cmp("incPC",       {31'b0, incPC},     {31'b0, exp_inc});
      cmp("pc_enable",   {31'b0, pc_enable}, {31'b0, exp_inc});
      cmp("mem_addr",    mem_addr,           m_addr);
      cmp("IR",          IR,                 m_ir);
      cmp("fetch_count", fetch_count,        cntExp(m_fetches));
      cmp("stall_count", stall_count,        cntExp(m_stalls));
   endtask

   // Called on a falling edge: drive inputs, check, advance model, next fall.
   task automatic applyStimulus(input bit go, input bit redir, input bit rdy,
                                input logic [31:0] rdata, input bit ack);
      fetch_go  = go;
      redirect  = redir;
      mem_ready = rdy;
      mem_rdata = rdata;
      ir_ack    = ack;
      PC        = pc_reg;
      #1;
      checkOutput();
      modelStep(go, redir, rdy, rdata, ack);
      @(negedge clock);
   endtask

   task automatic doReset();
      clear     = 1'b1;
      fetch_go  = 1'b0;
      redirect  = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      ir_ack    = 1'b0;
      PC        = 32'h0;
      repeat (2) @(negedge clock);
      clear = 1'b0;
      modelReset();
   endtask

   // Main sequence: reset, fixed vector table, directed corner cases, then
   // randomized traffic against the model.
   initial begin
      passed = 0;
      total  = 0;
      target_pc = 32'h200;
      pc_reg    = 32'h100;

      vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   TB_RESET_IR,  0};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, TB_RESET_IR,  0};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h104, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 1};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h104, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h104, 32'hDEADBEEF, 1};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h104, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'hCAFEF00D, 2};

      doReset();
      #1;
      cmp("reset_mem_read", {31'b0, mem_read}, 32'h0);
      cmp("reset_busy",     {31'b0, busy},     32'h0);
      cmp("reset_ir_valid", {31'b0, ir_valid}, 32'h0);
      cmp("reset_incPC",    {31'b0, incPC},    32'h0);
      cmp("reset_IR",       IR,                TB_RESET_IR);
      cmp("reset_mem_addr", mem_addr,          32'h0);
      cmp("reset_fetch_count", fetch_count,    32'h0);
      @(negedge clock);

      for (int i = 0; i < 6; i++) begin
         fetch_go  = vecs[i].go;
         redirect  = vecs[i].redir;
         mem_ready = vecs[i].rdy;
         PC        = vecs[i].pc;
         mem_rdata = vecs[i].rdata;
         ir_ack    = vecs[i].ack;
         #1;
         cmp($sformatf("vec%0d_mem_read", i),  {31'b0, mem_read},  {31'b0, vecs[i].exp_read});
         cmp($sformatf("vec%0d_busy", i),      {31'b0, busy},      {31'b0, vecs[i].exp_busy});
         cmp($sformatf("vec%0d_ir_valid", i),  {31'b0, ir_valid},  {31'b0, vecs[i].exp_valid});
         cmp($sformatf("vec%0d_incPC", i),     {31'b0, incPC},     {31'b0, vecs[i].exp_inc});
         cmp($sformatf("vec%0d_pc_enable", i), {31'b0, pc_enable}, {31'b0, vecs[i].exp_inc});
         cmp($sformatf("vec%0d_mem_addr", i),  mem_addr,           vecs[i].exp_addr);
         cmp($sformatf("vec%0d_IR", i),        IR,                 vecs[i].exp_ir);
         cmp($sformatf("vec%0d_fetch_count", i), fetch_count,      cntExp(vecs[i].exp_fetches));
         @(negedge clock);
      end

      doReset();
      pc_reg = 32'h140;
      applyStimulus(1, 0, 0, 32'h0, 0);
      repeat (4) applyStimulus(0, 0, 0, $urandom, 0);
      applyStimulus(0, 0, 1, 32'h12345678, 0);
      cmp("wait_stall_count", stall_count, cntExp(4));
      cmp("wait_fetch_count", fetch_count, cntExp(1));
      cmp("wait_IR",          IR,          32'h12345678);
      repeat (10) applyStimulus(1, 0, 1, $urandom, 0);
      cmp("hold_IR_stable", IR, 32'h12345678);
      applyStimulus(0, 0, 0, 32'h0, 1);
      applyStimulus(0, 0, 0, 32'h0, 0);

      doReset();
      pc_reg = 32'h100;
      applyStimulus(1, 0, 0, 32'h0, 0);
      applyStimulus(0, 1, 1, 32'hCAFEF00D, 0);
      cmp("redir_req_IR",          IR,                TB_RESET_IR);
      cmp("redir_req_busy",        {31'b0, busy},     32'h0);
      cmp("redir_req_fetch_count", fetch_count,       cntExp(0));
      applyStimulus(0, 0, 0, 32'h0, 0);

      doReset();
      pc_reg    = 32'h100;
      target_pc = 32'h200;
      applyStimulus(1, 0, 1, 32'hDEADBEEF, 0);
      applyStimulus(0, 0, 1, 32'hDEADBEEF, 0);
      applyStimulus(0, 1, 0, 32'h0, 0);
      applyStimulus(1, 0, 0, 32'h0, 0);
      cmp("redir_inc_target_addr", mem_addr,          32'h200);
      cmp("redir_inc_ir_valid",    {31'b0, ir_valid}, 32'h0);

      doReset();
      pc_reg = 32'h100;
      applyStimulus(1, 0, 0, 32'h0, 0);
      fetch_go  = 1'b0;
      mem_ready = 1'b0;
      #2;
      clear = 1'b1;
      #1;
      cmp("clear_req_mem_read", {31'b0, mem_read}, 32'h0);
      cmp("clear_req_busy",     {31'b0, busy},     32'h0);
      cmp("clear_req_ir_valid", {31'b0, ir_valid}, 32'h0);
      cmp("clear_req_incPC",    {31'b0, incPC},    32'h0);
      cmp("clear_req_IR",       IR,                TB_RESET_IR);
      @(negedge clock);
      mem_ready = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
      @(negedge clock);
      clear = 1'b0;
      modelReset();
      applyStimulus(0, 0, 1, 32'hBAD0BAD0, 0);
      applyStimulus(0, 0, 1, 32'hBAD0BAD0, 0);

      applyStimulus(1, 0, 0, 32'h0, 0);
      applyStimulus(0, 0, 1, 32'h55AA55AA, 0);
      fetch_go  = 1'b0;
      mem_ready = 1'b0;
      redirect  = 1'b0;
      #1;
      cmp("pre_clear_incPC", {31'b0, incPC}, 32'h1);
      #1;
      clear = 1'b1;
      #1;
      cmp("clear_inc_incPC",     {31'b0, incPC},     32'h0);
      cmp("clear_inc_pc_enable", {31'b0, pc_enable}, 32'h0);
      cmp("clear_inc_ir_valid",  {31'b0, ir_valid},  32'h0);
      @(negedge clock);
      clear = 1'b0;
      modelReset();

      pc_reg = 32'h1000;
      for (int c = 0; c < 400; c++) begin
         target_pc = {$urandom} & 32'hFFFF_FFFC;
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1);
      end

      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
